icache_refill_ctrl: RTL

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl_pkg.sv | 16 +
 rtl/icache_refill_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the I-cache refill controller.
//   - default geometry (address width, word width, words per line)
//   - refill FSM state encoding
package icache_refill_ctrl_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller.
// On a miss, captures the line base address and reads LINE_WORDS words from
// backing memory one request at a time, writing each returned word into the
// cache data array. Finishes with a one-cycle done pulse so the cache can set
// tag and valid bit.
// Ports:
//   Clk, Rst         clock, synchronous active-high reset
//   i_miss           miss from the fetch stage
//   i_miss_addr      byte address of the missing fetch
//   o_busy           high while a refill is in progress (FETCH and DONE)
//   o_mem_req        memory read request, held until i_mem_ack
//   o_mem_addr       word-aligned read address
//   i_mem_ack        read data valid
//   i_mem_rdata      read data
//   o_line_we        write strobe to the data array (same cycle as ack)
//   o_line_addr      line base address
//   o_line_word      word slot being written
//   o_line_wdata     word being written
//   o_refill_done    one-cycle completion pulse
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          i_miss,
  input  logic [ADDR_W-1:0]             i_miss_addr,
  output logic                          o_busy,
  output logic                          o_mem_req,
  output logic [ADDR_W-1:0]             o_mem_addr,
  input  logic                          i_mem_ack,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  output logic                          o_line_we,
  output logic [ADDR_W-1:0]             o_line_addr,
  output logic [$clog2(LINE_WORDS)-1:0] o_line_word,
  output logic [DATA_W-1:0]             o_line_wdata,
  output logic                          o_refill_done
);

  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int WORD_BYTES = DATA_W / 8;
  localparam int LINE_BYTES = LINE_WORDS * WORD_BYTES;

  refill_state_t       state;
  logic [ADDR_W-1:0]   base;
  logic [WORD_W-1:0]   cnt;
  logic [WORD_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]   miss_base;
  logic                last_word;

  // Offset bits of the miss address are cleared to form the line base.
  assign miss_base = i_miss_addr & ~ADDR_W'(LINE_BYTES - 1);
  // Counter is exactly WORD_W bits wide, so the increment wraps to 0 on its own.
  assign cnt_inc   = cnt + 1'b1;
  assign last_word = (cnt == WORD_W'(LINE_WORDS - 1));

  // Data-array write follows the ack combinationally; acks outside FETCH
  // never reach the array.
  assign o_line_we    = (state == ST_FETCH) && i_mem_ack;
  assign o_line_addr  = base;
  assign o_line_word  = cnt;
  assign o_line_wdata = i_mem_rdata;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= ST_IDLE;
      base          <= '0;
      cnt           <= '0;
      o_busy        <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
      o_refill_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_refill_done <= 1'b0;
          if (i_miss) begin
            base       <= miss_base;
            cnt        <= '0;
            o_mem_addr <= miss_base;
            o_mem_req  <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Miss inputs are not looked at here: a flush never aborts a refill.
          if (i_mem_ack) begin
            cnt <= cnt_inc;
            if (last_word) begin
              o_mem_req     <= 1'b0;
              o_refill_done <= 1'b1;
              state         <= ST_DONE;
            end else begin
              o_mem_addr <= base + ADDR_W'(cnt_inc) * ADDR_W'(WORD_BYTES);
            end
          end
        end
        ST_DONE: begin
          o_refill_done <= 1'b0;
          o_busy        <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          o_refill_done <= 1'b0;
          o_busy        <= 1'b0;
          o_mem_req     <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
